// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for cdc_fifo: pointer width rule, ADDR_WIDTH legality and Gray/binary conversion.
package cdc_fifo_pkg;

  localparam int MIN_ADDR_W = 2;
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_PTR_W  = MAX_ADDR_W + 1;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  // Pointers carry one wrap bit above the memory address.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit addr_width_legal(input int addr_w);
    return (addr_w >= MIN_ADDR_W) && (addr_w <= MAX_ADDR_W);
  endfunction

  // Both conversions run at the widest pointer; zero-extended narrower pointers convert unchanged.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = g;
    for (int s = 1; s < MAX_PTR_W; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_fifo_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
module gray_ptr_sync #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             not_reset,
  input  logic [PTR_W-1:0] gray_in,
  output logic [PTR_W-1:0] gray_out
);

  logic [PTR_W-1:0] meta_q;
  logic [PTR_W-1:0] sync_q;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= gray_in;
      sync_q <= meta_q;
    end
  end

  assign gray_out = sync_q;

endmodule

// File: rtl/cdc_fifo.sv
// Dual-clock Gray-pointer FIFO with registered flags, fill counts and sticky error flags.
// Define CDC_FIFO_FWFT_EN for first-word-fall-through output; otherwise dout is registered on read.
module cdc_fifo
  import cdc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  not_reset,
  input  logic                  rd_clk,
  input  logic                  wr_clk,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ptr_width(ADDR_WIDTH);

  if (!addr_width_legal(ADDR_WIDTH)) begin : g_bad_addr_width
    $error("cdc_fifo: ADDR_WIDTH must be in 2..8");
  end

  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t to_gray(input ptr_t b);
    return ptr_t'(bin2gray(ptr_max_t'(b)));
  endfunction

  function automatic ptr_t to_bin(input ptr_t g);
    return ptr_t'(gray2bin(ptr_max_t'(g)));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, wr_count_q, wr_count_d;
  ptr_t rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d, rd_count_q, rd_count_d;
  ptr_t rd_gray_wsync, wr_gray_rsync;
  logic full_q, full_d, almost_full_q, almost_full_d, overflow_q, overflow_d;
  logic empty_q, empty_d, almost_empty_q, almost_empty_d, underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic wr_en, rd_en;

  gray_ptr_sync #(.PTR_W(PTR_W)) u_rd2wr (
    .clk      (wr_clk),
    .not_reset(not_reset),
    .gray_in  (rd_gray_q),
    .gray_out (rd_gray_wsync)
  );

  gray_ptr_sync #(.PTR_W(PTR_W)) u_wr2rd (
    .clk      (rd_clk),
    .not_reset(not_reset),
    .gray_in  (wr_gray_q),
    .gray_out (wr_gray_rsync)
  );

  // Write domain: flags are computed from the post-write pointer so full lands on the filling edge.
  always_comb begin
    wr_en         = write & ~full_q;
    wr_bin_d      = wr_bin_q + ptr_t'(wr_en);
    wr_gray_d     = to_gray(wr_bin_d);
    full_d        = (wr_gray_d == {~rd_gray_wsync[PTR_W-1 -: 2], rd_gray_wsync[PTR_W-3:0]});
    wr_count_d    = wr_bin_d - to_bin(rd_gray_wsync);
    almost_full_d = (wr_count_d >= ptr_t'(AF_LEVEL));
    overflow_d    = overflow_q | (write & full_q);
  end

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem_q[wr_bin_q[ADDR_WIDTH-1:0]] <= din;
  end

  always_ff @(posedge wr_clk or negedge not_reset) begin
    if (!not_reset) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Read domain: memory slots below the synchronised write pointer are stable, so reading them here is safe.
  always_comb begin
    rd_en          = read & ~empty_q;
    rd_bin_d       = rd_bin_q + ptr_t'(rd_en);
    rd_gray_d      = to_gray(rd_bin_d);
    empty_d        = (rd_gray_d == wr_gray_rsync);
    rd_count_d     = to_bin(wr_gray_rsync) - rd_bin_d;
    almost_empty_d = (rd_count_d <= ptr_t'(AE_LEVEL));
    underflow_d    = underflow_q | (read & empty_q);
`ifdef CDC_FIFO_FWFT_EN
    dout_d = empty_d ? dout_q : mem_q[rd_bin_d[ADDR_WIDTH-1:0]];
`else
    dout_d = rd_en ? mem_q[rd_bin_q[ADDR_WIDTH-1:0]] : dout_q;
`endif
  end

  always_ff @(posedge rd_clk or negedge not_reset) begin
    if (!not_reset) begin
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      rd_count_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
      dout_q         <= '0;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      rd_count_q     <= rd_count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
      dout_q         <= dout_d;
    end
  end

  assign dout         = dout_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_cdc_fifo.sv
// Scoreboard bench for cdc_fifo: directed cases plus randomized traffic at 1:3 and 3:1 clock ratios.
`timescale 1ns/10ps
module tb_cdc_fifo;

  localparam int DW    = 64;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = DEPTH - 1;
  localparam int AE    = 1;

  logic          not_reset, rd_clk, wr_clk, write, read;
  logic [DW-1:0] din, dout;
  logic          empty, almost_empty, full, almost_full, overflow, underflow;
  logic [AW:0]   rd_count, wr_count;

  cdc_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .not_reset(not_reset), .rd_clk(rd_clk), .wr_clk(wr_clk), .din(din),
    .write(write), .read(read), .dout(dout), .empty(empty),
    .almost_empty(almost_empty), .full(full), .almost_full(almost_full),
    .rd_count(rd_count), .wr_count(wr_count), .overflow(overflow), .underflow(underflow)
  );

  real wr_half = 5.0;
  real rd_half = 8.5;
  initial begin wr_clk = 1'b0; forever #(wr_half) wr_clk = ~wr_clk; end
  initial begin rd_clk = 1'b0; forever #(rd_half) rd_clk = ~rd_clk; end

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] dout_exp = '0;
  logic ovf_exp = 1'b0;
  logic unf_exp = 1'b0;
  int   wr_acc = 0;
  logic wr_take, rd_take;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write-side monitor: accepted words enter the reference queue in order.
  always @(posedge wr_clk) begin
    wr_take = write && !full;
    if (wr_take) begin sb.push_back(din); wr_acc++; end
    if (write && full) ovf_exp = 1'b1;
    #1;
    if (not_reset) begin
      chk("overflow", 64'(overflow), 64'(ovf_exp));
      chk("wr_count_bound", 64'(wr_count >= sb.size() && wr_count <= DEPTH), 64'(1));
      chk("full_vs_count", 64'(full), 64'(wr_count == DEPTH));
      chk("almost_full", 64'(almost_full), 64'(wr_count >= AF));
    end
  end

  // Read-side monitor: pops the head on every accepted read and checks dout.
  always @(posedge rd_clk) begin
    rd_take = read && !empty;
    if (read && empty) unf_exp = 1'b1;
`ifndef CDC_FIFO_FWFT_EN
    if (rd_take) begin
      if (sb.size() == 0) chk("sb_underrun", 64'(1), 64'(0));
      else dout_exp = sb.pop_front();
    end
`else
    if (rd_take) begin
      if (sb.size() == 0) chk("sb_underrun", 64'(1), 64'(0));
      else void'(sb.pop_front());
    end
`endif
    #1;
    if (not_reset) begin
`ifdef CDC_FIFO_FWFT_EN
      if (!empty) begin
        if (sb.size() == 0) chk("fwft_head_missing", 64'(1), 64'(0));
        else dout_exp = sb[0];
      end
`endif
      chk("dout", dout, dout_exp);
      chk("underflow", 64'(underflow), 64'(unf_exp));
      chk("rd_count_bound", 64'(rd_count <= sb.size()), 64'(1));
      chk("empty_vs_count", 64'(empty), 64'(rd_count == 0));
      chk("almost_empty", 64'(almost_empty), 64'(rd_count <= AE));
    end
  end

  task automatic check_reset_values();
    chk("rst_dout", dout, 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_almost_empty", 64'(almost_empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_almost_full", 64'(almost_full), 64'(0));
    chk("rst_rd_count", 64'(rd_count), 64'(0));
    chk("rst_wr_count", 64'(wr_count), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_underflow", 64'(underflow), 64'(0));
  endtask

  task automatic assert_reset();
    not_reset = 1'b0;
    write = 1'b0;
    read = 1'b0;
    sb.delete();
    dout_exp = '0;
    ovf_exp = 1'b0;
    unf_exp = 1'b0;
  endtask

  task automatic wr_word(input logic [DW-1:0] d);
    @(negedge wr_clk); write = 1'b1; din = d;
  endtask
  task automatic wr_idle(); @(negedge wr_clk); write = 1'b0; endtask
  task automatic rd_word(); @(negedge rd_clk); read = 1'b1; endtask
  task automatic rd_idle(); @(negedge rd_clk); read = 1'b0; endtask

  task automatic run_random(input int n);
    int target;
    target = wr_acc + n;
    fork
      begin : writer
        int bud;
        bud = 0;
        forever begin
          @(negedge wr_clk);
          if (wr_acc >= target || bud >= 20000) break;
          write = ($urandom % 2) == 1;
          din = {$urandom, $urandom};
          bud++;
        end
        write = 1'b0;
        if (wr_acc < target) chk("writer_budget", 64'(wr_acc), 64'(target));
      end
      begin : reader
        int bud;
        bud = 0;
        forever begin
          @(negedge rd_clk);
          if ((wr_acc >= target && sb.size() == 0) || bud >= 20000) break;
          read = ($urandom % 2) == 1;
          bud++;
        end
        read = 1'b0;
        if (sb.size() != 0) chk("reader_budget", 64'(sb.size()), 64'(0));
      end
    join
    repeat (6) @(posedge rd_clk);
    #1;
    chk("drain_empty", 64'(empty), 64'(1));
    chk("drain_rd_count", 64'(rd_count), 64'(0));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    din = '0;
    assert_reset();
    #30;
    check_reset_values();
    @(negedge wr_clk); not_reset = 1'b1;

    // In-order transfer of three words.
    wr_word(64'hA1); wr_word(64'hA2); wr_word(64'hA3); wr_idle();
    repeat (5) @(posedge rd_clk);
    rd_word(); rd_word(); rd_word(); rd_idle();
    #1;
    chk("t1_empty", 64'(empty), 64'(1));
    chk("t1_underflow", 64'(underflow), 64'(0));

    // Empty falls within 3 read edges of a single write.
    repeat (4) @(posedge wr_clk);
    wr_word(64'h5A);
    @(posedge wr_clk);
    fork begin #1 write = 1'b0; end join_none
    edges = 0;
    do begin
      @(posedge rd_clk); #1; edges++;
    end while (empty && edges < 4);
    chk("empty_fall_edges_ok", 64'(edges <= 3), 64'(1));
    chk("empty_fall_rd_count", 64'(rd_count), 64'(1));
    rd_word();
    @(posedge rd_clk); #1;
    chk("last_read_empty", 64'(empty), 64'(1));
    rd_idle();

    // Fill to full, then one dropped write.
    repeat (6) @(posedge wr_clk);
    for (int i = 0; i < DEPTH; i++) wr_word(64'hC0 + 64'(i));
    @(posedge wr_clk); #1;
    chk("full_on_fill", 64'(full), 64'(1));
    chk("wr_count_full", 64'(wr_count), 64'(DEPTH));
    wr_word(64'hDEAD);
    @(posedge wr_clk); #1;
    chk("overflow_set", 64'(overflow), 64'(1));
    wr_idle();
    repeat (4) rd_word();
    rd_idle();
    repeat (6) @(posedge wr_clk); #1;
    chk("full_cleared", 64'(full), 64'(0));

    // Reset with two words stored.
    wr_word(64'h11); wr_word(64'h22); wr_idle();
    repeat (5) @(posedge rd_clk);
    @(negedge rd_clk); #2;
    assert_reset();
    #1;
    check_reset_values();
    repeat (2) @(negedge wr_clk);
    not_reset = 1'b1;
    wr_word(64'h77); wr_idle();
    repeat (5) @(posedge rd_clk);
    rd_word(); rd_idle();
    #1;
    chk("post_reset_empty", 64'(empty), 64'(1));

    // Randomized traffic at both clock ratios.
    @(negedge wr_clk);
    wr_half = 5.0; rd_half = 15.15;
    run_random(500);
    wr_half = 15.15; rd_half = 5.0;
    run_random(500);
    $display("info: accepted writes=%0d pointer wraps=%0d", wr_acc, wr_acc / (2 * DEPTH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_fifo.md
# cdc_fifo

Parametrised dual-clock FIFO that carries cache-line data between the memory-side write clock and the cache-side read clock. It replaces the status-latch FIFO generation: both pointers are (ADDR_WIDTH+1)-bit Gray codes crossed through two-flop synchronisers. All flags and fill counts are registered. It adds programmable almost-full/almost-empty thresholds, per-domain fill counts and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 64, data word width (cache string width)
- ADDR_WIDTH, 2, log2 of depth; legal range 2..8
- DEPTH, 1<<ADDR_WIDTH, derived, not overridable
- AF_LEVEL, DEPTH-1, almost_full asserts when wr_count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when rd_count <= AE_LEVEL
- not_reset  in  1  asynchronous, active-low reset; clears both domains
- rd_clk  in  1  read clock
- wr_clk  in  1  write clock
- din  in  DATA_WIDTH  write data
- write  in  1  write request (wr_clk)
- read  in  1  read request (rd_clk)
- dout  out  DATA_WIDTH  read data (rd_clk)
- empty, almost_empty  out  1  rd_clk domain flags
- full, almost_full  out  1  wr_clk domain flags
- rd_count  out  ADDR_WIDTH+1  rd-side occupancy, 0..DEPTH
- wr_count  out  ADDR_WIDTH+1  wr-side occupancy, 0..DEPTH
- overflow  out  1  sticky: write while full (wr_clk)
- underflow  out  1  sticky: read while empty (rd_clk)

## Operation
- Binary pointers wr_bin and rd_bin are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address memory and the MSB is the wrap bit. Gray copy = bin ^ (bin>>1), registered.
- Write accepted iff write & ~full: mem[wr_bin[ADDR_WIDTH-1:0]] <= din, wr_bin++ (wraps modulo 2^(ADDR_WIDTH+1)).
- Read accepted iff read & ~empty: rd_bin++. dout behaviour depends on configuration.
- Write while full: dropped, no pointer change, overflow <= 1. Read while empty: dropped, underflow <= 1. Both flags clear only on reset.
- empty is set when the next rd Gray pointer equals the synchronised wr Gray pointer.
- full is set when the next wr Gray pointer equals the synchronised rd Gray pointer with its top two bits inverted.
- Counts: each domain converts the synchronised Gray pointer to binary, then computes (wr_bin - rd_bin) mod 2^(ADDR_WIDTH+1). The counts are pessimistic: rd_count may under-report and wr_count may over-report by the synchroniser lag.
- Memory contents are not reset.
- On reset: dout=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_count=0, wr_count=0, overflow=0, underflow=0, all pointers and synchroniser flops 0.

## Timing
- Same-domain flags update on the clock edge that accepts the operation. A write that fills the FIFO sets full on that same wr_clk edge. A read of the last word sets empty on that same rd_clk edge.
- Cross-domain update takes 2 synchroniser edges plus 1 flag register edge. After the wr_clk edge that moves wr_gray, empty falls on the 3rd rd_clk rising edge; the 2nd edge is permitted if the phase allows. The same applies to full clearing after a read, counted in wr_clk edges.
- Simultaneous read and write in their own domains are always legal. When full, a read in the same interval frees a slot only after the cross-domain delay.
- Reset mid-transfer: both domains return to reset values immediately (asynchronously), and in-flight data is discarded.
- Non-FWFT read latency: dout takes mem[rd addr] on the rd_clk edge that accepts the read, and is valid from that edge until the next accepted read.

## Configuration
- CDC_FIFO_FWFT_EN defined: first-word-fall-through.
  - dout continuously shows the head word whenever empty=0.
  - read acts as acknowledge and pops the head; dout shows the next word after the same edge.
  - dout keeps its last value while empty.
- Undefined: standard registered-read behaviour as in Timing.

## Structure
- Shared package cdc_fifo_pkg holds:
  - bin2gray and gray2bin functions, parametrised by width
  - PTR_W = ADDR_WIDTH+1 convention
  - the ADDR_WIDTH legality check
- Sub-module gray_ptr_sync: a PTR_W-wide two-flop synchroniser with async active-low reset, instantiated once per direction.

## Test plan
- Reset, then write 0xA1, 0xA2, 0xA3 (wr_clk 10 ns, rd_clk 17 ns), then read 3 times -> dout 0xA1, 0xA2, 0xA3 in order; empty=1 at the end; underflow=0.
- Write 4 words into DEPTH=4 -> full=1 on the 4th accepted edge; wr_count=4; a 5th write sets overflow=1 and memory is unchanged.
- After a write into an empty FIFO -> empty falls within 3 rd_clk edges; rd_count reaches 1 on the same edge.
- 1000 random words, random read/write enables, clock ratios 1:3 and 3:1 -> scoreboard matches with no loss or duplication; pointer wrap is exercised more than 100 times.
- Assert not_reset with 2 words stored -> all outputs take reset values immediately; the next write/read pair returns the new word only.
- With CDC_FIFO_FWFT_EN, write 0x55 -> dout=0x55 as soon as empty falls, with read=0; pulse read -> empty=1.
